// File: rtl/regfile_write_bus.sv
// Write side of the 32 x 32-bit register file, driven out as one flat 1024-bit bus.
// Holds a per-register dirty mask and a sequenced bulk-clear sweep over registers 1..31.
module regfile_write_bus #(
   parameter int NUM_REGS = 32,
   parameter int WIDTH    = 32,
   parameter int SEL_W    = 5
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      write_en,
   input  logic [SEL_W-1:0]          write_sel,
   input  logic [WIDTH-1:0]          write_data,
   input  logic                      clear_req,
   output logic                      ready,
   output logic                      clear_busy,
   output logic                      write_ack,
   output logic [NUM_REGS-1:0]       dirty,
   output logic [NUM_REGS*WIDTH-1:0] regs
);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

   state_t                      state_q, state_d;
   logic [SEL_W-1:0]            cnt_q, cnt_d;
   logic [NUM_REGS*WIDTH-1:0]   regs_q, regs_d;
   logic [NUM_REGS-1:0]         dirty_q, dirty_d;
   logic                        ack_q, ack_d;

   // Handshake: write_en and clear_req are taken at a rising edge only while ready = 1;
   // while ready = 0 both are dropped, and an accepted write is acknowledged by write_ack one cycle later.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      regs_d  = regs_q;
      dirty_d = dirty_q;
      ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (write_en) begin
               ack_d = 1'b1;
               for (int k = 1; k < NUM_REGS; k++) begin
                  if (write_sel == SEL_W'(k)) begin
                     regs_d[k*WIDTH +: WIDTH] = write_data;
                     dirty_d[k]               = 1'b1;
                  end
               end
            end
            if (clear_req) begin
               state_d = CLEAR;
               cnt_d   = SEL_W'(1);
            end
         end
         CLEAR: begin
            for (int k = 1; k < NUM_REGS; k++) begin
               if (cnt_q == SEL_W'(k)) begin
                  regs_d[k*WIDTH +: WIDTH] = '0;
                  dirty_d[k]               = 1'b0;
               end
            end
            // The counter parks at the last index; the next clear request reloads it.
            if (cnt_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + SEL_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= SEL_W'(1);
         regs_q  <= '0;
         dirty_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
         dirty_q <= dirty_d;
         ack_q   <= ack_d;
      end
   end

   assign ready      = (state_q == IDLE);
   assign clear_busy = (state_q == CLEAR);
   assign write_ack  = ack_q;
   assign dirty      = dirty_q;
   assign regs       = regs_q;

endmodule

// File: tb/tb_regfile_write_bus.sv
// Bench for regfile_write_bus: directed vector table, hand-written sweep sequences,
// then random traffic checked every cycle against a queue-based reference model.
module tb_regfile_write_bus;

   logic          clock;
   logic          reset_n;
   logic          write_en;
   logic [4:0]    write_sel;
   logic [31:0]   write_data;
   logic          clear_req;
   logic          ready;
   logic          clear_busy;
   logic          write_ack;
   logic [31:0]   dirty;
   logic [1023:0] regs;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: register contents, dirty mask, and a queue of indices still to sweep.
   bit [31:0] m_regs[32];
   bit [31:0] m_dirty;
   bit        m_ack;
   int        sweep_q[$];

   regfile_write_bus dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .write_en   (write_en),
      .write_sel  (write_sel),
      .write_data (write_data),
      .clear_req  (clear_req),
      .ready      (ready),
      .clear_busy (clear_busy),
      .write_ack  (write_ack),
      .dirty      (dirty),
      .regs       (regs)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1023:0] model_bus();
      logic [1023:0] b;
      for (int k = 0; k < 32; k++) b[k*32 +: 32] = m_regs[k];
      return b;
   endfunction

   function automatic logic [31:0] reg_of(input int k);
      logic [1023:0] b;
      b = regs;
      return b[k*32 +: 32];
   endfunction

   // Advance the model by one rising edge using the rules of the block.
   task automatic model_edge(input bit rst_n, input bit we, input bit [4:0] sel,
                             input bit [31:0] data, input bit clr);
      int idx;
      if (!rst_n) begin
         foreach (m_regs[k]) m_regs[k] = '0;
         m_dirty = '0;
         m_ack   = 1'b0;
         sweep_q.delete();
      end else if (sweep_q.size() != 0) begin
         idx = sweep_q.pop_front();
         m_regs[idx]  = '0;
         m_dirty[idx] = 1'b0;
         m_ack        = 1'b0;
      end else begin
         m_ack = we;
         if (we && sel != 0) begin
            m_regs[sel]  = data;
            m_dirty[sel] = 1'b1;
         end
         if (clr) for (int k = 1; k < 32; k++) sweep_q.push_back(k);
      end
   endtask

   // Drive one cycle of inputs, step the model, and compare every output after the edge.
   task automatic step(input bit rst_n, input bit we, input bit [4:0] sel,
                       input bit [31:0] data, input bit clr);
      reset_n    = rst_n;
      write_en   = we;
      write_sel  = sel;
      write_data = data;
      clear_req  = clr;
      model_edge(rst_n, we, sel, data, clr);
      @(posedge clock);
      #1;
      chk("ready",      1024'(ready),      1024'(sweep_q.size() == 0));
      chk("clear_busy", 1024'(clear_busy), 1024'(sweep_q.size() != 0));
      chk("write_ack",  1024'(write_ack),  1024'(m_ack));
      chk("dirty",      1024'(dirty),      1024'(m_dirty));
      chk("regs",       regs,              model_bus());
   endtask

   task automatic idle_step();
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   typedef struct {
      bit        rst_n;
      bit        we;
      bit [4:0]  sel;
      bit [31:0] data;
      int        chk_idx;
      bit [31:0] exp_val;
      bit        exp_ack;
      bit [31:0] exp_dirty;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int sweep_n;
      bit [31:0] exp_d;
      logic [1023:0] exp_b;

      // Directed vectors: {rst_n, we, sel, data, checked reg, its value, ack, dirty}.
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,        5,  32'h0,        1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5,  32'hDEADBEEF, 1'b1, 32'h20});
      vecs.push_back('{1'b1, 1'b0, 5'd0,  32'h0,        5,  32'hDEADBEEF, 1'b0, 32'h20});
      vecs.push_back('{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 0,  32'h0,        1'b1, 32'h20});
      vecs.push_back('{1'b1, 1'b0, 5'd0,  32'h0,        0,  32'h0,        1'b0, 32'h20});
      vecs.push_back('{1'b0, 1'b0, 5'd0,  32'h0,        5,  32'h0,        1'b0, 32'h0});
      vecs.push_back('{1'b1, 1'b1, 5'd3,  32'h11,       3,  32'h11,       1'b1, 32'h08});
      vecs.push_back('{1'b1, 1'b1, 5'd4,  32'h22,       4,  32'h22,       1'b1, 32'h18});
      vecs.push_back('{1'b1, 1'b1, 5'd3,  32'h33,       3,  32'h33,       1'b1, 32'h18});
      vecs.push_back('{1'b1, 1'b0, 5'd0,  32'h0,        4,  32'h22,       1'b0, 32'h18});
      vecs.push_back('{1'b1, 1'b0, 5'd0,  32'h0,        3,  32'h33,       1'b0, 32'h18});

      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("reset_regs",  regs,           '0);
      chk("reset_ready", 1024'(ready),   1024'(1));

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].we, vecs[i].sel, vecs[i].data, 1'b0);
         chk($sformatf("vec%0d_reg", i),   1024'(reg_of(vecs[i].chk_idx)), 1024'(vecs[i].exp_val));
         chk($sformatf("vec%0d_ack", i),   1024'(write_ack),                1024'(vecs[i].exp_ack));
         chk($sformatf("vec%0d_dirty", i), 1024'(dirty),                    1024'(vecs[i].exp_dirty));
      end

      // Fill regs 1..31 with their own index, then sweep.
      for (int k = 1; k < 32; k++) step(1'b1, 1'b1, 5'(k), 32'(k), 1'b0);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
      chk("sweep_start_busy", 1024'(clear_busy), 1024'(1));
      sweep_n = 0;
      for (int c = 1; c <= 40 && !ready; c++) begin
         if (c == 12) begin
            step(1'b1, 1'b1, 5'd20, 32'hFFFF, 1'b0);
            chk("midsweep_write_ack", 1024'(write_ack),  1024'(0));
            chk("midsweep_write_reg", 1024'(reg_of(20)), 1024'(20));
         end else begin
            idle_step();
         end
         sweep_n++;
         if (c == 10) begin
            exp_b = '0;
            exp_d = '0;
            for (int k = 11; k < 32; k++) begin
               exp_b[k*32 +: 32] = 32'(k);
               exp_d[k]          = 1'b1;
            end
            chk("after_10_sweep_regs",  regs,        exp_b);
            chk("after_10_sweep_dirty", 1024'(dirty), 1024'(exp_d));
         end
      end
      chk("sweep_length",      1024'(sweep_n), 1024'(31));
      chk("after_sweep_regs",  regs,           '0);
      chk("after_sweep_dirty", 1024'(dirty),   '0);
      chk("after_sweep_ready", 1024'(ready),   1024'(1));

      // Write and clear in the same cycle: write lands, then the last sweep step zeroes it.
      step(1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b1);
      chk("same_cycle_ack",  1024'(write_ack),  1024'(1));
      chk("same_cycle_reg",  1024'(reg_of(31)), 1024'(32'hA5A5A5A5));
      for (int c = 1; c < 31; c++) idle_step();
      chk("reg31_before_last", 1024'(reg_of(31)), 1024'(32'hA5A5A5A5));
      chk("busy_before_last",  1024'(clear_busy), 1024'(1));
      idle_step();
      chk("reg31_after_last",  1024'(reg_of(31)), 1024'(0));
      chk("ready_after_last",  1024'(ready),      1024'(1));

      // Reset in the 15th sweep cycle, then a fresh full sweep from reg1.
      for (int k = 1; k < 32; k++) step(1'b1, 1'b1, 5'(k), 32'h100 + 32'(k), 1'b0);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
      for (int c = 1; c < 15; c++) idle_step();
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("midsweep_reset_ready", 1024'(ready), 1024'(1));
      chk("midsweep_reset_regs",  regs,         '0);
      chk("midsweep_reset_dirty", 1024'(dirty), '0);
      step(1'b1, 1'b1, 5'd1, 32'h77, 1'b0);
      step(1'b1, 1'b1, 5'd2, 32'h88, 1'b0);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
      idle_step();
      chk("resweep_reg1_first", 1024'(reg_of(1)), 1024'(0));
      chk("resweep_reg2_held",  1024'(reg_of(2)), 1024'(32'h88));
      sweep_n = 1;
      for (int c = 2; c <= 40 && !ready; c++) begin
         idle_step();
         sweep_n++;
      end
      chk("resweep_length", 1024'(sweep_n), 1024'(31));

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) != 0),
              1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)),
              $urandom,
              ($urandom_range(0, 39) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_bus.md
Name: regfile_write_bus

Overview:
- Write side of the flattened register-file bus.
- Holds 32 x 32-bit registers and drives them as a single 1024-bit bus (reg k at bits [32k+31:32k]). The read-side 32:1 bus muxes consume this bus unchanged.
- Accepts one decoded register write per cycle and tracks a per-register dirty mask.
- Supports a sequenced bulk-clear sweep used on game restart.
- Register 0 is hardwired to zero.

Parameters:
- NUM_REGS, 32, number of registers (fixed at 32 for bus compatibility).
- WIDTH, 32, bits per register.
- SEL_W, 5, width of register select.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- write_en  input  1  write request for the current cycle.
- write_sel  input  5  destination register index.
- write_data  input  32  data to write.
- clear_req  input  1  request a bulk clear of registers 1..31.
- ready  output  1  1 when writes and clear requests are accepted (FSM in IDLE).
- clear_busy  output  1  1 while the clear sweep is in progress.
- write_ack  output  1  one-cycle pulse the cycle after an accepted write.
- dirty  output  32  bit k = 1 if reg k has been written since the last reset or clear; bit 0 is always 0.
- regs  output  1024  flattened register contents.

Behaviour:
- Reset (reset_n = 0 at rising edge): all registers = 0, dirty = 0, write_ack = 0, clear_busy = 0, ready = 1, FSM = IDLE, sweep counter = 1. Reset has priority over all other inputs, including mid-sweep.
- Registered outputs: regs, dirty and write_ack are registered. ready and clear_busy decode directly from FSM state.
- FSM states: IDLE, CLEAR.
- IDLE, write accepted: if write_en = 1, the write is accepted at that edge.
  - If write_sel != 0: regs[write_sel] <= write_data and dirty[write_sel] <= 1. Visible on regs the next cycle (1-cycle latency).
  - If write_sel == 0: data is discarded, reg0 stays 0, dirty[0] stays 0.
  - write_ack = 1 the cycle after any accepted write, including sel 0. Otherwise write_ack = 0.
- Back-to-back writes: one per cycle. A later write to the same index overwrites the earlier one. There is no read-modify-write.
- IDLE, clear request: if clear_req = 1, go to CLEAR next cycle and load counter = 1.
  - A simultaneous write_en in the same cycle is still performed and acked. It is overwritten by the sweep when the counter reaches its index.
- CLEAR sweep: ready = 0, clear_busy = 1.
  - Each cycle: regs[counter] <= 0, dirty[counter] <= 0, counter++.
  - When counter = 31 is cleared, return to IDLE next cycle.
  - Sweep duration is exactly 31 cycles in CLEAR.
- CLEAR, ignored inputs: write_en is ignored (no update, no ack). clear_req is ignored.
- Wrap-around: the counter never wraps. Reaching 31 terminates the sweep, and the counter reloads to 1 on the next clear.
- X/invalid handling: write_sel is always 5 bits, so there are no out-of-range indices.

Test Plan:
- Reset, then write_en = 1, sel = 5, data = 0xDEADBEEF for one cycle -> next cycle regs[191:160] = 0xDEADBEEF, write_ack = 1 for exactly 1 cycle, dirty = 0x00000020. All other register fields stay 0.
- Write sel = 0, data = 0xFFFFFFFF -> regs[31:0] = 0, dirty[0] = 0, write_ack pulses once.
- Writes to sel 3, 4, 3 on consecutive cycles with data 0x11, 0x22, 0x33 -> reg3 = 0x33, reg4 = 0x22, three ack pulses, dirty = 0x00000018.
- Fill regs 1..31 with value k, then pulse clear_req -> ready low and clear_busy high for 31 cycles.
  - Mid-sweep, at the 10th CLEAR cycle, regs 1..10 = 0 and regs 11..31 still hold k.
  - A write to sel 20 issued mid-sweep gets no ack and no effect.
  - After the sweep: all regs 0, dirty = 0, ready = 1.
- clear_req and write (sel 31, data 0xA5A5A5A5) asserted in the same IDLE cycle -> write acked, reg31 = 0xA5A5A5A5 until the last sweep cycle, then 0.
- reset_n driven low at the 15th CLEAR cycle -> next cycle FSM IDLE, all regs 0, dirty 0, ready 1. A following clear_req sweeps the full 31 cycles starting at reg1.
